// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide arbiter and the shift-add unit.
// Holds the arbiter state encoding, the operation codes carried on
// req_sel/select, and the internal state encoding of multi_div.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_PREP = 2'd2,
    MD_OUT  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports:
//   req     - request vector
//   last    - index of the most recently granted requester
//   win     - one-hot winner (zero when no request)
//   win_idx - index of the winner
//   any     - at least one request is present
// The search starts at last+1 and wraps, so the previous winner has lowest
// priority.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  int   idx;
  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        win[idx]     = 1'b1;
        win_idx      = IDX_W'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/multi_div.sv
// multi_div: iterative shift-add multiplier / restoring divider.
// Ports:
//   clk, reset (async, active-high)
//   en       - one-cycle start strobe, operands sampled with it
//   select   - MD_MUL or MD_DIV
//   A, B     - operands (two's complement when SIGNED != 0)
//   P        - product, or {remainder, quotient} for a divide
//   div_zero - divide by zero, qualified by Valid
//   Valid    - one-cycle result strobe
//   Busy     - an operation is in flight
// Works on magnitudes for SIZE_A/STEP_SIZE cycles, then applies the signs in
// one extra cycle. A zero divisor skips the iteration and answers next cycle.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module multi_div
  import muldiv_pkg::*;
#(
  parameter int SIZE_A    = 12,
  parameter int SIZE_B    = 12,
  parameter int SIGNED    = 1,
  parameter int STEP_SIZE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     select,
  input  logic [SIZE_A-1:0]        A,
  input  logic [SIZE_B-1:0]        B,
  output logic [SIZE_A+SIZE_B-1:0] P,
  output logic                     div_zero,
  output logic                     Valid,
  output logic                     Busy
);

  localparam int C     = SIZE_A / STEP_SIZE;
  localparam int CNT_W = $clog2(C + 1);

  md_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       dz_q, dz_d;
  logic [SIZE_B:0]            hi_q, hi_d;
  logic [SIZE_A-1:0]          lo_q, lo_d;
  logic [SIZE_B-1:0]          div_q, div_d;
  logic                       sel_q, sel_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [SIZE_A+SIZE_B-1:0]   p_q, p_d;

  logic                       sa, sb;
  logic [SIZE_A-1:0]          mag_a, q_s;
  logic [SIZE_B-1:0]          mag_b, r_s;
  logic [SIZE_B:0]            sum;
  logic [SIZE_A+SIZE_B-1:0]   prod;

  assign sa    = (SIGNED != 0) && A[SIZE_A-1];
  assign sb    = (SIGNED != 0) && B[SIZE_B-1];
  assign mag_a = sa ? -A : A;
  assign mag_b = sb ? -B : B;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    sel_d   = sel_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    p_d     = p_q;
    sum     = '0;
    prod    = '0;
    q_s     = '0;
    r_s     = '0;
    case (state_q)
      MD_IDLE: begin
        if (en) begin
          sel_d   = select;
          neg_a_d = sa;
          neg_b_d = sb;
          div_d   = mag_b;
          hi_d    = '0;
          lo_d    = mag_a;
          cnt_d   = '0;
          dz_d    = 1'b0;
          if (select == MD_DIV && B == '0) begin
            dz_d    = 1'b1;
            p_d     = '0;
            state_d = MD_OUT;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        // {hi, lo} is the product accumulator (shifting right) for a
        // multiply, and the {remainder, quotient} pair (shifting left) for
        // a divide.
        for (int s = 0; s < STEP_SIZE; s++) begin
          if (sel_q == MD_MUL) begin
            sum          = lo_d[0] ? hi_d + {1'b0, div_q} : hi_d;
            {hi_d, lo_d} = {sum, lo_d} >> 1;
          end else begin
            {hi_d, lo_d} = {hi_d[SIZE_B-1:0], lo_d, 1'b0};
            if (hi_d >= {1'b0, div_q}) begin
              hi_d    = hi_d - {1'b0, div_q};
              lo_d[0] = 1'b1;
            end
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(C - 1)) state_d = MD_PREP;
      end
      MD_PREP: begin
        if (sel_q == MD_MUL) begin
          prod = {hi_q[SIZE_B-1:0], lo_q};
          p_d  = (neg_a_q ^ neg_b_q) ? -prod : prod;
        end else begin
          q_s = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
          r_s = neg_a_q ? -hi_q[SIZE_B-1:0] : hi_q[SIZE_B-1:0];
          p_d = {r_s, q_s};
        end
        state_d = MD_OUT;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    div_q   <= div_d;
    sel_q   <= sel_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
    p_q     <= p_d;
  end

  assign P        = p_q;
  assign div_zero = dz_q;
  assign Valid    = (state_q == MD_OUT);
  assign Busy     = (state_q != MD_IDLE);

endmodule

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: shares one multi_div among NUM_REQ requesters.
// Ports:
//   clk, reset (async, active-low)
//   req, req_sel      - per-requester request level and op (0 mul, 1 div)
//   req_a, req_b      - packed operands, requester i at [i*SIZE +: SIZE]
//   gnt               - registered one-hot grant, held until the done cycle
//   done              - registered one-hot completion pulse
//   result, div_zero  - registered result and flag, qualified by done
//   busy              - state is not IDLE
// Sequence: IDLE (pick) -> ISSUE (en) -> WAIT (Valid) -> RESP (done) -> IDLE.
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_A    = 12,
  parameter int SIZE_B    = 12,
  parameter int SIGNED    = 1,
  parameter int STEP_SIZE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_sel,
  input  logic [NUM_REQ*SIZE_A-1:0] req_a,
  input  logic [NUM_REQ*SIZE_B-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [SIZE_A+SIZE_B-1:0]  result,
  output logic                      div_zero,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int RES_W = SIZE_A + SIZE_B;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                div_zero_q, div_zero_d;
  logic [SIZE_A-1:0]   a_q, a_d;
  logic [SIZE_B-1:0]   b_q, b_d;
  logic                sel_q, sel_d;

  logic [NUM_REQ-1:0]  win;
  logic [IDX_W-1:0]    win_idx;
  logic                any_req;
  logic [RES_W-1:0]    md_p;
  logic                md_dz, md_valid, md_busy_unused;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any_req)
  );

  multi_div #(
    .SIZE_A    (SIZE_A),
    .SIZE_B    (SIZE_B),
    .SIGNED    (SIGNED),
    .STEP_SIZE (STEP_SIZE)
  ) u_md (
    .clk      (clk),
    .reset    (~reset),
    .en       (state_q == ST_ISSUE),
    .select   (sel_q),
    .A        (a_q),
    .B        (b_q),
    .P        (md_p),
    .div_zero (md_dz),
    .Valid    (md_valid),
    .Busy     (md_busy_unused)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          last_d  = win_idx;
          a_d     = req_a[int'(win_idx)*SIZE_A +: SIZE_A];
          b_d     = req_b[int'(win_idx)*SIZE_B +: SIZE_B];
          sel_d   = req_sel[win_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // No cycle counting: divide-by-zero comes back early.
        if (md_valid) begin
          result_d   = md_p;
          div_zero_d = md_dz;
          done_d     = gnt_q;
          state_d    = ST_RESP;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Captured operands only matter between grant and Valid.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sel_q <= sel_d;
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
module tb_muldiv_arbiter;

  localparam int NR     = 4;
  localparam int SA     = 12;
  localparam int SB     = 12;
  localparam int RW     = SA + SB;
  localparam int C      = SA;
  localparam int LAT_OP = C + 4;
  localparam int LAT_DZ = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     req_sel = '0;
  logic [NR*SA-1:0]  req_a = '0;
  logic [NR*SB-1:0]  req_b = '0;
  logic [NR-1:0]     gnt, done;
  logic [RW-1:0]     result;
  logic              div_zero, busy;

  muldiv_arbiter #(
    .NUM_REQ(NR), .SIZE_A(SA), .SIZE_B(SB), .SIGNED(1), .STEP_SIZE(1)
  ) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .done(done),
    .result(result), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [RW-1:0] res;
    logic          dz;
    int            at;
  } exp_t;

  typedef struct {
    int            rise;
    int            len;   // 0: held until done; else pulse length in cycles
    logic [SA-1:0] a;
    logic [SB-1:0] b;
    logic          sel;
  } rq_t;

  exp_t          sb[$];
  rq_t           rq[NR];
  logic [NR-1:0] use_m = '0;
  int            model_ptr = NR - 1;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic exp_t ref_op(int idx, logic [SA-1:0] a, logic [SB-1:0] b,
                                  logic sel, int t);
    exp_t e;
    int ai, bi, q, r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    e.idx = idx;
    e.dz  = 1'b0;
    e.res = '0;
    e.at  = t + LAT_OP;
    if (!sel) begin
      e.res = RW'(ai * bi);
    end else if (bi == 0) begin
      e.dz = 1'b1;
      e.at = t + LAT_DZ;
    end else begin
      q = ai / bi;
      r = ai % bi;
      e.res = {r[SB-1:0], q[SA-1:0]};
    end
    return e;
  endfunction

  task automatic set_rq(input int i, input int rise, input int len,
                        input int a, input int b, input logic sel);
    rq[i].rise = rise;
    rq[i].len  = len;
    rq[i].a    = SA'(a);
    rq[i].b    = SB'(b);
    rq[i].sel  = sel;
    use_m[i]   = 1'b1;
  endtask

  // Plan the service order at transaction level, push expectations, then
  // drive the requester levels cycle by cycle until everything is served.
  task automatic run_scenario();
    int n0, t, j, t_end, budget;
    logic [NR-1:0] pend, act, lower;
    bit finished;
    exp_t e;
    n0 = cyc;
    t = n0;
    pend = use_m;
    for (int g = 0; g < 4000 && pend != '0; g++) begin
      act = '0;
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          if (rq[i].len > 0 && t >= rq[i].rise + rq[i].len) pend[i] = 1'b0;
          else if (t >= rq[i].rise) act[i] = 1'b1;
        end
      end
      if (act == '0) begin
        t++;
      end else begin
        j = -1;
        for (int k = 1; k <= NR; k++)
          if (j < 0 && act[(model_ptr + k) % NR]) j = (model_ptr + k) % NR;
        e = ref_op(j, rq[j].a, rq[j].b, rq[j].sel, t);
        sb.push_back(e);
        model_ptr = j;
        pend[j] = 1'b0;
        t = e.at + 1;
      end
    end
    t_end = t;
    budget = t_end - n0 + 40;
    lower = '0;
    finished = 0;
    for (int k = 0; k < budget; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (use_m[i]) begin
          if (cyc == rq[i].rise) begin
            req_a[i*SA +: SA] = rq[i].a;
            req_b[i*SB +: SB] = rq[i].b;
            req_sel[i]        = rq[i].sel;
            req[i]            = 1'b1;
          end
          if (rq[i].len > 0 && cyc == rq[i].rise + rq[i].len) req[i] = 1'b0;
        end
      end
      req = req & ~lower;
      if (cyc >= t_end && !busy && sb.size() == 0 && req == '0) begin
        finished = 1;
        break;
      end
      @(negedge clk);
      lower = done;
      @(posedge clk);
      #1;
    end
    chk("scenario_complete", 32'(finished), 32'd1);
    use_m = '0;
  endtask

  // Monitor: every done pulse is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done != '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=%b with nothing outstanding (cycle %0d)",
                   done, cyc);
        end else begin
          e = sb.pop_front();
          chk("done_onehot", 32'(done), 32'(1) << e.idx);
          chk("done_cycle", 32'(cyc), 32'(e.at));
          chk("gnt_at_done", 32'(gnt), 32'(done));
          chk("busy_at_done", 32'(busy), 32'd1);
          chk("div_zero", 32'(div_zero), 32'(e.dz));
          if (!e.dz) chk("result", 32'(result), 32'(e.res));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All four together, held: served 0,1,2,3.
    set_rq(0, cyc, 0, 10, 20, 1'b0);
    set_rq(1, cyc, 0, -300, 7, 1'b1);
    set_rq(2, cyc, 0, 45, -3, 1'b0);
    set_rq(3, cyc, 0, 1000, -33, 1'b1);
    run_scenario();

    // 0 and 2 together: 0 first.
    set_rq(0, cyc, 0, -7, -9, 1'b0);
    set_rq(2, cyc, 0, 77, 5, 1'b1);
    run_scenario();

    // Single multiply.
    set_rq(0, cyc, 0, -5, 7, 1'b0);
    run_scenario();

    // Divide by zero.
    set_rq(1, cyc, 0, 100, 0, 1'b1);
    run_scenario();

    // Extremes.
    set_rq(0, cyc, 0, -2048, -2048, 1'b0);
    run_scenario();
    set_rq(0, cyc, 0, 2047, -1, 1'b0);
    run_scenario();

    // Late held request and a short withdrawn pulse.
    set_rq(0, cyc, 0, 123, -45, 1'b0);
    set_rq(2, cyc + 5, 0, -100, 3, 1'b0);
    set_rq(1, cyc + 7, 2, 9, 9, 1'b0);
    run_scenario();

    // Reset in the middle of an operation by requester 1.
    n0 = cyc;
    req_a[1*SA +: SA] = SA'(5);
    req_b[1*SB +: SB] = SB'(6);
    req_sel[1] = 1'b0;
    req[1] = 1'b1;
    while (cyc < n0 + 8) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_gnt", 32'(gnt), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_result", 32'(result), 32'd0);
    chk("midreset_div_zero", 32'(div_zero), 32'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_ptr = NR - 1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("postreset_idle", 32'(busy), 32'd0);

    // Pointer back at reset: 0 beats 2 even though 1 was granted last.
    set_rq(0, cyc, 0, -11, 13, 1'b0);
    set_rq(2, cyc, 0, 600, -25, 1'b1);
    run_scenario();
    set_rq(3, cyc, 0, 3, 4, 1'b0);
    run_scenario();

    // Randomized mixes of held, late and pulsed requests.
    for (int s = 0; s < 25; s++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          logic sel;
          int b;
          sel = 1'($urandom_range(0, 1));
          b = int'($urandom_range(0, 4095));
          if (sel && $urandom_range(0, 4) == 0) b = 0;
          set_rq(i, cyc + int'($urandom_range(0, 20)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                 int'($urandom_range(0, 4095)), b, sel);
        end
      end
      run_scenario();
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Round-robin arbiter and sequencer that shares one `multi_div` shift-add multiplier/divider among `NUM_REQ` requesters. Each requester holds a request with its operands and operation select. The block grants one requester at a time, launches the operation, waits for the unit's `Valid`, and returns the result with a one-cycle `done` pulse to the winner. It sits between the geometry engines (for example the geofence cross-product steps) and the single arithmetic unit, so more engines can be added without more multipliers.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `SIZE_A`, 12, operand A width
- `SIZE_B`, 12, operand B width
- `SIGNED`, 1, passed to `multi_div`; 1 means two's-complement operands
- `STEP_SIZE`, 1, passed to `multi_div`; shift steps per cycle, must divide `SIZE_A`

Ports:
- `clk` in 1: the single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-requester request level.
- `req_sel` in `NUM_REQ`: per-requester operation, 0 = multiply, 1 = divide.
- `req_a` in `NUM_REQ*SIZE_A`: packed operand A, requester i at `[i*SIZE_A +: SIZE_A]`.
- `req_b` in `NUM_REQ*SIZE_B`: packed operand B, same packing.
- `gnt` out `NUM_REQ`: one-hot grant, registered.
- `done` out `NUM_REQ`: one-hot completion pulse, registered.
- `result` out `SIZE_A+SIZE_B`: registered result, qualified by `done`.
- `div_zero` out 1: divide-by-zero flag, qualified by `done`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Reset values:** all outputs 0, state IDLE, round-robin pointer `last` = `NUM_REQ-1`, so requester 0 has first priority.
- The `multi_div` reset input is driven by `~reset`, because that unit resets active-high.
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req` is set, pick the first set bit searching upward from `last+1`, wrapping modulo `NUM_REQ`.
  - Register that requester's a, b and sel, set `gnt` one-hot, update `last`, go to ISSUE.
  - If no `req` is set, stay in IDLE.
- **ISSUE:** `en` = 1 for exactly this cycle, with the captured operands. Go to WAIT.
- **WAIT:**
  - Hold until `multi_div.Valid` = 1.
  - On that edge, register P into `result` and `div_zero` into the flag, then go to RESP.
  - No cycle counting: the divide-by-zero path returns early and must work.
- **RESP:**
  - `done[g]` = 1 for one cycle. `gnt` and `busy` are still high.
  - Next state IDLE. `gnt` clears on entry to IDLE.
- **Requester rules:**
  - A requester keeps `req` and its operands stable from assertion until it samples `done`.
  - It lowers `req` in the cycle after `done` unless it wants another operation.
  - A `req` still high when the block re-enters IDLE counts as a new request.
  - Withdrawing `req` before it is granted is legal. Withdrawing after grant is ignored; the operation still completes.
- **Arithmetic:** sign handling is done entirely by `multi_div`. `result` is `SIZE_A+SIZE_B` bits and is sign-correct when `SIGNED` = 1.
- **Reset mid-operation:** the in-flight operation is discarded and no `done` is produced. After release, the pointer is back at its reset value.

## Timing
- Let C = `SIZE_A/STEP_SIZE`.
- Request sampled in IDLE at cycle t. Then:
  - t+1: ISSUE
  - t+2 .. t+1+C: multi_div CALCULATE
  - t+2+C: multi_div PREPARE
  - t+3+C: Valid
  - t+4+C: `done`
- Request-to-done latency is C+4 cycles, which is 16 for the defaults.
- Divide by zero: Valid at t+2 and `done` at t+3, a latency of 3.
- Back-to-back throughput is one operation per C+5 cycles, because RESP always returns to IDLE.
- `gnt` is high from t+1 through the `done` cycle inclusive.
- `busy` follows the state with no extra delay.

## Structure
- Shared package/include `muldiv_pkg` holds:
  - state encodings `ST_IDLE`=0, `ST_ISSUE`=1, `ST_WAIT`=2, `ST_RESP`=3
  - operation codes `MD_MUL`=0, `MD_DIV`=1
- Sub-modules:
  - one `multi_div` instance, with `select` tied to the captured sel and `Busy` left unused
  - one natural helper, `rr_pick`: combinational round-robin priority encoder taking (req, last) and returning a one-hot winner plus its index

## Test plan
- **Single multiply:** `req[0]`, a=-5, b=7, sel=0 at t → `gnt[0]` at t+1, `done[0]` at t+16, `result`=-35, `div_zero`=0.
- **Simultaneous requests:** all four `req` raised together and held → `done` order 0,1,2,3, spaced 17 cycles apart. Then `req[0]` and `req[2]` raised together → 0 is served before 2.
- **Divide by zero:** `req[1]`, sel=1, a=100, b=0 → `done[1]` at t+3, `div_zero`=1, no other `done` bits set.
- **Extremes:** a=-2048, b=-2048, sel=0 → `result`=4194304. Then a=2047, b=-1 → `result`=-2047.
- **Reset mid-operation:** `reset` driven low at t+8 of an operation → all outputs 0 immediately and no `done`. After release, `req[3]` with a=3, b=4 gives `result`=12 sixteen cycles later, and pointer state matches reset.
- **Late and withdrawn requests:** `req[2]` raised mid-operation of requester 0 and held → granted in the first IDLE after `done[0]`. `req[1]` pulsed for 2 cycles while busy → never granted.
